// File: rtl/mdio_phy_manager_if.sv
// AXI-Lite bundle between the PHY manager and the MDIO master.
// Addresses are MDIO register numbers; data is one 16-bit MDIO register.
interface axi_lite_interface;
  logic [4:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [15:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [15:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport Master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport Slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/mdio_phy_manager.sv
// PHY bring-up and periodic link polling over AXI-Lite to the MDIO master.
// One transaction at a time; each transaction starts with an idle cycle.
//
// state        | meaning
// STARTUP      | power-on delay before first access
// WR_RESET     | write BMCR = 0x8000 (PHY soft reset)
// POLL_RESET   | read BMCR until the reset bit self-clears
// WR_CONFIG    | write BMCR = BMCR_CONFIG
// WAIT_POLL    | interval between poll rounds, services restart_an
// RD_BMSR      | read BMSR, hold link / AN bits
// RD_PHYSTS    | read PHYSTS, publish status
// FAULT        | back-off before re-running the reset sequence
module mdio_phy_manager #(
  parameter logic [31:0] STARTUP_CYCLES     = 32'd1_250_000,
  parameter logic [31:0] POLL_CYCLES        = 32'd12_500_000,
  parameter logic [31:0] RESET_POLL_MAX     = 32'd16,
  parameter logic [31:0] TXN_TIMEOUT_CYCLES = 32'd1_000_000,
  parameter logic [15:0] BMCR_CONFIG        = 16'h1200,
  parameter logic [4:0]  PHYSTS_ADDR        = 5'h10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_an,
  output logic init_done,
  output logic link_up,
  output logic an_complete,
  output logic speed_100,
  output logic full_duplex,
  output logic status_valid,
  output logic error,
  axi_lite_interface.Master axi_lite
);

  localparam logic [2:0] ST_STARTUP    = 3'd0;
  localparam logic [2:0] ST_WR_RESET   = 3'd1;
  localparam logic [2:0] ST_POLL_RESET = 3'd2;
  localparam logic [2:0] ST_WR_CONFIG  = 3'd3;
  localparam logic [2:0] ST_WAIT_POLL  = 3'd4;
  localparam logic [2:0] ST_RD_BMSR    = 3'd5;
  localparam logic [2:0] ST_RD_PHYSTS  = 3'd6;
  localparam logic [2:0] ST_FAULT      = 3'd7;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_ADDR = 2'd1;
  localparam logic [1:0] PH_DATA = 2'd2;
  localparam logic [1:0] PH_RESP = 2'd3;

  logic [2:0]  state;
  logic [1:0]  phase;
  logic [31:0] timer;
  logic [31:0] wdog;
  logic        restart_pend;
  logic        bmsr_link;
  logic        bmsr_an;

  logic        txn_state;
  logic        txn_write;
  logic [4:0]  txn_addr;
  logic [15:0] txn_data;

  always_comb begin
    txn_state = 1'b1;
    txn_write = 1'b0;
    txn_addr  = 5'h00;
    txn_data  = 16'h0000;
    case (state)
      ST_WR_RESET: begin
        txn_write = 1'b1;
        txn_data  = 16'h8000;
      end
      ST_POLL_RESET: txn_addr = 5'h00;
      ST_WR_CONFIG: begin
        txn_write = 1'b1;
        txn_data  = BMCR_CONFIG;
      end
      ST_RD_BMSR:   txn_addr = 5'h01;
      ST_RD_PHYSTS: txn_addr = PHYSTS_ADDR;
      default:      txn_state = 1'b0;
    endcase
  end

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic txn_done, txn_ok, resp_bad, wdog_exp, poll_exceeded, fault_now;

  assign aw_hs = axi_lite.awvalid & axi_lite.awready;
  assign w_hs  = axi_lite.wvalid & axi_lite.wready;
  assign b_hs  = axi_lite.bvalid & axi_lite.bready;
  assign ar_hs = axi_lite.arvalid & axi_lite.arready;
  assign r_hs  = axi_lite.rvalid & axi_lite.rready;

  assign txn_done      = (phase == PH_RESP) & (b_hs | r_hs);
  assign resp_bad      = b_hs ? (axi_lite.bresp != 2'b00) : (axi_lite.rresp != 2'b00);
  assign txn_ok        = txn_done & ~resp_bad;
  assign wdog_exp      = (phase != PH_IDLE) & (wdog == 32'd0) & ~(b_hs | r_hs);
  // In POLL_RESET the timer holds the remaining retry budget
  assign poll_exceeded = (state == ST_POLL_RESET) & txn_ok & axi_lite.rdata[15] & (timer == 32'd0);
  assign fault_now     = wdog_exp | (txn_done & resp_bad) | poll_exceeded;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_STARTUP;
      phase            <= PH_IDLE;
      timer            <= STARTUP_CYCLES;
      wdog             <= 32'd0;
      restart_pend     <= 1'b0;
      bmsr_link        <= 1'b0;
      bmsr_an          <= 1'b0;
      init_done        <= 1'b0;
      link_up          <= 1'b0;
      an_complete      <= 1'b0;
      speed_100        <= 1'b0;
      full_duplex      <= 1'b0;
      status_valid     <= 1'b0;
      error            <= 1'b0;
      axi_lite.awaddr  <= 5'h00;
      axi_lite.awvalid <= 1'b0;
      axi_lite.wdata   <= 16'h0000;
      axi_lite.wvalid  <= 1'b0;
      axi_lite.bready  <= 1'b0;
      axi_lite.araddr  <= 5'h00;
      axi_lite.arvalid <= 1'b0;
      axi_lite.rready  <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      // WAIT_POLL consumes a pending request; a pulse in that same cycle survives
      restart_pend <= (restart_pend & (state != ST_WAIT_POLL)) | restart_an;

      if (txn_state) begin
        if (phase != PH_IDLE) wdog <= wdog - 32'd1;
        case (phase)
          PH_IDLE: begin
            phase <= PH_ADDR;
            wdog  <= TXN_TIMEOUT_CYCLES;
            if (txn_write) begin
              axi_lite.awvalid <= 1'b1;
              axi_lite.awaddr  <= txn_addr;
              axi_lite.wdata   <= txn_data;
            end else begin
              axi_lite.arvalid <= 1'b1;
              axi_lite.araddr  <= txn_addr;
            end
          end
          PH_ADDR: begin
            if (aw_hs) begin
              axi_lite.awvalid <= 1'b0;
              axi_lite.wvalid  <= 1'b1;
              phase            <= PH_DATA;
            end else if (ar_hs) begin
              axi_lite.arvalid <= 1'b0;
              axi_lite.rready  <= 1'b1;
              phase            <= PH_RESP;
            end
          end
          PH_DATA: begin
            if (w_hs) begin
              axi_lite.wvalid <= 1'b0;
              axi_lite.bready <= 1'b1;
              phase           <= PH_RESP;
            end
          end
          default: begin
            if (b_hs | r_hs) begin
              axi_lite.bready <= 1'b0;
              axi_lite.rready <= 1'b0;
              phase           <= PH_IDLE;
            end
          end
        endcase
      end

      case (state)
        ST_STARTUP, ST_FAULT: begin
          if (timer == 32'd0) state <= ST_WR_RESET;
          else timer <= timer - 32'd1;
        end
        ST_WR_RESET: begin
          if (txn_ok) begin
            state <= ST_POLL_RESET;
            timer <= RESET_POLL_MAX;
          end
        end
        ST_POLL_RESET: begin
          if (txn_ok) begin
            if (!axi_lite.rdata[15]) state <= ST_WR_CONFIG;
            else if (timer != 32'd0) timer <= timer - 32'd1;
          end
        end
        ST_WR_CONFIG: begin
          if (txn_ok) begin
            init_done <= 1'b1;
            state     <= ST_WAIT_POLL;
            timer     <= POLL_CYCLES;
          end
        end
        ST_WAIT_POLL: begin
          if (restart_pend) state <= ST_WR_CONFIG;
          else if (timer == 32'd0) state <= ST_RD_BMSR;
          else timer <= timer - 32'd1;
        end
        ST_RD_BMSR: begin
          if (txn_ok) begin
            bmsr_link <= axi_lite.rdata[2];
            bmsr_an   <= axi_lite.rdata[5];
            state     <= ST_RD_PHYSTS;
          end
        end
        default: begin
          if (txn_ok) begin
            link_up      <= bmsr_link;
            an_complete  <= bmsr_an;
            speed_100    <= ~axi_lite.rdata[1];
            full_duplex  <= axi_lite.rdata[2];
            status_valid <= 1'b1;
            state        <= ST_WAIT_POLL;
            timer        <= POLL_CYCLES;
          end
        end
      endcase

      // Any fault abandons the transaction and overrides the state update above
      if (fault_now) begin
        error            <= 1'b1;
        init_done        <= 1'b0;
        link_up          <= 1'b0;
        state            <= ST_FAULT;
        timer            <= POLL_CYCLES;
        phase            <= PH_IDLE;
        axi_lite.awvalid <= 1'b0;
        axi_lite.wvalid  <= 1'b0;
        axi_lite.bready  <= 1'b0;
        axi_lite.arvalid <= 1'b0;
        axi_lite.rready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_manager.sv
// Bench for mdio_phy_manager: randomized-latency MDIO slave model, transaction
// log compared against the expected PHY management sequence.
module tb_mdio_phy_manager;
  localparam int STARTUP = 10;
  localparam int POLL    = 50;
  localparam int RPM     = 3;
  localparam int TOUT    = 200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic restart_an = 1'b0;
  logic init_done, link_up, an_complete, speed_100, full_duplex, status_valid, error;

  axi_lite_interface axi();

  mdio_phy_manager #(
    .STARTUP_CYCLES    (32'(STARTUP)),
    .POLL_CYCLES       (32'(POLL)),
    .RESET_POLL_MAX    (32'(RPM)),
    .TXN_TIMEOUT_CYCLES(32'(TOUT)),
    .BMCR_CONFIG       (16'h1200),
    .PHYSTS_ADDR       (5'h10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .restart_an  (restart_an),
    .init_done   (init_done),
    .link_up     (link_up),
    .an_complete (an_complete),
    .speed_100   (speed_100),
    .full_duplex (full_duplex),
    .status_valid(status_valid),
    .error       (error),
    .axi_lite    (axi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // PHY register model and slave controls
  int          busy_left = 0;
  logic [15:0] bmsr_val = 16'h002C;
  logic [15:0] physts_val = 16'h0005;
  bit          stall_cfg = 0;
  bit          stall_all_w = 0;
  bit          stale_b = 0;
  int          stale_cnt = 0;

  bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic [4:0]  aw_addr_q, ar_addr_q;
  logic [21:0] log_q[$];
  int          cyc = 0;
  int          b_hs_count = 0;
  int          aw_ar_overlap = 0;

  // Monitor: records completed handshakes at the clock edge
  initial begin
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    aw_addr_q = 5'h00; ar_addr_q = 5'h00;
    forever begin
      @(posedge clk);
      cyc++;
      if (axi.awvalid && axi.arvalid) aw_ar_overlap++;
      if (axi.awvalid && axi.awready) begin hs_aw = 1; aw_addr_q = axi.awaddr; end
      if (axi.wvalid && axi.wready) begin hs_w = 1; log_q.push_back({1'b1, aw_addr_q, axi.wdata}); end
      if (axi.bvalid && axi.bready) begin hs_b = 1; b_hs_count++; end
      if (axi.arvalid && axi.arready) begin
        hs_ar = 1; ar_addr_q = axi.araddr;
        log_q.push_back({1'b0, axi.araddr, 16'h0000});
      end
      if (axi.rvalid && axi.rready) hs_r = 1;
    end
  end

  // Slave driver: updates its outputs on the falling edge
  initial begin
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 2'b00; axi.rvalid = 0; axi.rresp = 2'b00; axi.rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (!reset) begin
        axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.rvalid = 0;
        axi.bvalid = stale_b;
        stale_cnt = 8;
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        continue;
      end
      if (stale_cnt > 0) begin
        stale_cnt--;
        if (stale_cnt == 0 && stale_b) begin stale_b = 0; axi.bvalid = 0; end
      end
      if (hs_b) axi.bvalid = 0;
      if (hs_r) axi.rvalid = 0;
      if (hs_w) begin axi.bvalid = 1; axi.bresp = 2'b00; end
      if (hs_ar) begin
        axi.rvalid = 1; axi.rresp = 2'b00;
        case (ar_addr_q)
          5'h00: begin
            if (busy_left > 0) begin busy_left--; axi.rdata = 16'h8000; end
            else axi.rdata = 16'h0000;
          end
          5'h01:   axi.rdata = bmsr_val;
          5'h10:   axi.rdata = physts_val;
          default: axi.rdata = 16'hDEAD;
        endcase
      end
      hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
      axi.awready = axi.awvalid && ($urandom_range(0, 1) == 1);
      axi.wready  = axi.wvalid && !stall_all_w && !(stall_cfg && axi.wdata == 16'h1200)
                    && ($urandom_range(0, 1) == 1);
      axi.arready = axi.arvalid && ($urandom_range(0, 1) == 1);
    end
  end

  function automatic logic [63:0] outs_vec();
    return 64'({init_done, link_up, an_complete, speed_100, full_duplex, status_valid, error,
                axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                axi.awaddr, axi.araddr, axi.wdata});
  endfunction

  function automatic bit sig(input int which);
    case (which)
      0:       return status_valid;
      1:       return init_done;
      2:       return error;
      3:       return axi.awvalid;
      4:       return axi.wvalid;
      5:       return axi.arvalid && (axi.araddr == 5'h01);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_high(input string tag, input int which, input int limit, output int waited);
    waited = 0;
    while (!sig(which) && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_seen"}, 64'(sig(which)), 64'd1);
  endtask

  task automatic expect_txn(input string tag, input logic wr, input logic [4:0] a, input logic [15:0] d);
    int t;
    logic [21:0] e;
    t = 0;
    while (log_q.size() == 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (log_q.size() == 0) chk({tag, "_logged"}, 64'(log_q.size()), 64'd1);
    else begin
      e = log_q.pop_front();
      chk(tag, 64'(e), 64'({wr, a, d}));
    end
  endtask

  task automatic pulse_restart();
    restart_an = 1'b1;
    @(negedge clk);
    restart_an = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_bringup(input string tag);
    int w;
    expect_txn({tag, "_wr_reset"}, 1'b1, 5'h00, 16'h8000);
    expect_txn({tag, "_rd_bmcr"}, 1'b0, 5'h00, 16'h0000);
    expect_txn({tag, "_wr_config"}, 1'b1, 5'h00, 16'h1200);
    wait_high({tag, "_init_done"}, 1, 50, w);
  endtask

  initial begin
    int w;
    int prev_sv;
    logic [63:0] snap;
    logic [15:0] exp_bmsr, exp_phy;

    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_vec(), 64'd0);

    // 1: bring-up with a PHY that leaves reset immediately
    reset = 1'b1;
    wait_high("t1_first_aw", 3, 100, w);
    chk("t1_startup_wait", 64'(w >= STARTUP + 1 && w <= STARTUP + 4), 64'd1);
    expect_bringup("t1");
    chk("t1_error_clear", 64'(error), 64'd0);

    // 2: poll rounds with random register contents
    prev_sv = 0;
    for (int r = 0; r < 4; r++) begin
      exp_bmsr = bmsr_val;
      exp_phy  = physts_val;
      wait_high("t2_status_valid", 0, 300, w);
      chk("t2_link_up", 64'(link_up), 64'(exp_bmsr[2]));
      chk("t2_an_complete", 64'(an_complete), 64'(exp_bmsr[5]));
      chk("t2_speed_100", 64'(speed_100), 64'(!exp_phy[1]));
      chk("t2_full_duplex", 64'(full_duplex), 64'(exp_phy[2]));
      if (r > 0) chk("t2_poll_gap", 64'(cyc - prev_sv >= POLL + 1 && cyc - prev_sv <= POLL + 60), 64'd1);
      prev_sv = cyc;
      expect_txn("t2_rd_bmsr", 1'b0, 5'h01, 16'h0000);
      expect_txn("t2_rd_physts", 1'b0, 5'h10, 16'h0000);
      snap = outs_vec();
      @(negedge clk);
      chk("t2_sv_one_cycle", 64'(status_valid), 64'd0);
      repeat (20) @(negedge clk);
      chk("t2_stable", outs_vec(), snap & ~(64'd1 << 32));
      bmsr_val   = 16'($urandom);
      physts_val = 16'($urandom);
    end

    // 5: three restart pulses collapse into one BMCR write
    wait_high("t5_bmsr_ar", 5, 200, w);
    pulse_restart();
    pulse_restart();
    pulse_restart();
    expect_txn("t5_rd_bmsr", 1'b0, 5'h01, 16'h0000);
    expect_txn("t5_rd_physts", 1'b0, 5'h10, 16'h0000);
    expect_txn("t5_wr_config", 1'b1, 5'h00, 16'h1200);
    expect_txn("t5_next_bmsr", 1'b0, 5'h01, 16'h0000);
    expect_txn("t5_next_physts", 1'b0, 5'h10, 16'h0000);
    chk("t5_init_done", 64'(init_done), 64'd1);

    // 4: W channel stalls during BMCR config write
    stall_cfg = 1;
    pulse_restart();
    wait_high("t4_cfg_aw", 3, 200, w);
    prev_sv = cyc;
    wait_high("t4_error", 2, 400, w);
    chk("t4_wdog_time", 64'(cyc - prev_sv >= TOUT - 5 && cyc - prev_sv <= TOUT + 15), 64'd1);
    chk("t4_valids_low", 64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 64'd0);
    chk("t4_init_done", 64'(init_done), 64'd0);
    chk("t4_link_up", 64'(link_up), 64'd0);
    stall_cfg = 0;
    wait_high("t4_retry_aw", 3, 200, w);
    chk("t4_fault_wait", 64'(w >= POLL + 1 && w <= POLL + 5), 64'd1);
    expect_bringup("t4");
    chk("t4_error_sticky", 64'(error), 64'd1);

    // 3: PHY never clears its reset bit
    busy_left = 1000;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_reset_clears_error", 64'(error), 64'd0);
    log_q.delete();
    reset = 1'b1;
    expect_txn("t3_wr_reset", 1'b1, 5'h00, 16'h8000);
    for (int i = 0; i <= RPM; i++) expect_txn("t3_rd_bmcr", 1'b0, 5'h00, 16'h0000);
    wait_high("t3_error", 2, 50, w);
    chk("t3_init_done", 64'(init_done), 64'd0);
    busy_left = 0;
    wait_high("t3_retry_aw", 3, 200, w);
    chk("t3_fault_wait", 64'(w >= POLL + 1 && w <= POLL + 5), 64'd1);
    expect_bringup("t3_retry");

    // 6: reset while the W phase is pending, with a stale B response on the bus
    stall_all_w = 1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    log_q.delete();
    reset = 1'b1;
    wait_high("t6_wvalid", 4, 100, w);
    repeat (2) @(negedge clk);
    stale_b = 1;
    reset = 1'b0;
    #1;
    chk("t6_reset_immediate", outs_vec(), 64'd0);
    repeat (3) @(negedge clk);
    stall_all_w = 0;
    log_q.delete();
    b_hs_count = 0;
    reset = 1'b1;
    wait_high("t6_first_aw", 3, 100, w);
    chk("t6_startup_rerun", 64'(w >= STARTUP + 1 && w <= STARTUP + 4), 64'd1);
    chk("t6_no_stale_b", 64'(b_hs_count), 64'd0);
    expect_bringup("t6");
    chk("t6_error_clear", 64'(error), 64'd0);

    chk("aw_ar_overlap", 64'(aw_ar_overlap), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
